cos_range_reduce_ctrl: RTL and testbench
========================================

// Module: cos_range_reduce_ctrl
// PURPOSE
//  Upstream front end and sequencer for the fixed-point Taylor cosine core (Q.10, W=24).
//  - Accepts an arbitrary signed angle and reduces it to [0, HALF_PI] plus a sign flag.
//  - Drives the core's start/ready protocol and captures its result.
//  - Applies the sign and presents the full-range cosine on a valid/ready output.
// PARAMETERS
//  W           24    datapath width, two's complement, Q.FXP_SHIFT
//  FXP_SHIFT   10    fractional bits (1.0 = 1024)
//  TWO_PI      6434  2*pi in Q.10
//  PI          3217  pi in Q.10
//  HALF_PI     1608  pi/2 in Q.10
//  RED_STEPS   11    shift-subtract steps; TWO_PI<<(RED_STEPS-1) must be < 2^(W-1)
//  START_HOLD  3     minimum cycles core_start_out stays high
// PORTS
//  clock            in   1  single clock, rising edge
//  reset            in   1  synchronous, active-high
//  in_valid         in   1  angle_in valid
//  in_ready         out  1  block idle, can accept
//  angle_in         in   W  signed angle, Q.10, any value
//  out_valid        out  1  cos_out valid
//  out_ready        in   1  consumer accepts cos_out
//  cos_out          out  W  signed cosine, Q.10
//  core_start_out   out  1  to core start
//  core_angle_out   out  W  to core angle_in; unsigned, 0..HALF_PI
//  core_ready_in    in   1  from core ready_out
//  core_cos_in      in   W  from core cos_out
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, cos_out=0, core_start_out=0, core_angle_out=0,
//  state=IDLE. in_ready rises the cycle after reset is released.
//  Core shares clock/reset. Reset mid-operation aborts to IDLE and discards any result.
//  States and transitions:
//   IDLE:   in_ready=1. in_valid&in_ready -> ABS (latch angle).
//   ABS:    1 cycle. a=|angle|. -2^(W-1) saturates to 2^(W-1)-1.
//   REDUCE: RED_STEPS cycles, k = RED_STEPS-1 down to 0.
//           Each step: if a >= (TWO_PI<<k) then a -= TWO_PI<<k. Result 0 <= a < TWO_PI.
//   FOLD1:  if a > PI then a = TWO_PI - a.
//   FOLD2:  if a > HALF_PI then a = PI - a, neg=1; else neg=0.
//           Boundaries: a==PI stays in FOLD1, then becomes 0 with neg=1.
//           a==HALF_PI is not folded.
//   START:  core_angle_out=a; core_start_out=1.
//           Stay at least START_HOLD cycles AND until core_ready_in==0 is sampled.
//           Then drop core_start_out -> WAIT.
//           Hold time covers the core sitting in its done state with a stale ready=1.
//           It also covers the core after reset with ready=0 that has not yet sampled.
//   WAIT:   core_angle_out held stable. On core_ready_in==1:
//           cos_out = neg ? -core_cos_in : core_cos_in (W-bit wrap); out_valid=1 -> OUT.
//   OUT:    hold cos_out/out_valid until out_ready. On handshake: out_valid=0 -> IDLE.
//  core_start_out is first high in the 15th cycle after the accepting edge
//  (ABS 1 + REDUCE 11 + FOLD 2). in_ready is 0 outside IDLE; no pipelining, one angle in flight.
//  in_valid is ignored outside IDLE. angle_in needs to be valid only on the accepting edge.
// TESTING
//  angle_in=0 -> core_angle_out=0, neg=0; core gives ~1024 -> cos_out ~1024.
//  angle_in=3217 (PI) -> core_angle_out=0, neg=1 -> cos_out ~ -1024.
//  angle_in=-18802 -> core_angle_out=500, neg=0.
//  angle_in=2500 -> core_angle_out=717, neg=1 -> cos_out = -(core result).
//  angle_in=-8388608 -> saturates, core_angle_out=1329, neg=0.
//  Back-to-back ops with core left in done state (ready stale 1) -> second result is fresh.
//  Reset asserted in WAIT -> all outputs at reset values next cycle.
//  out_ready held 0 for 5 cycles -> cos_out and out_valid stable throughout.

Source files
------------

// File: rtl/cos_range_reduce_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cos_range_reduce_ctrl                                           |
// | Function : reduces a signed Q.10 angle to [0, pi/2] plus sign, sequences   |
// |            the Taylor cosine core and returns the signed full-range cosine |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cos_range_reduce_ctrl #(
  parameter int W          = 24,
  parameter int FXP_SHIFT  = 10,
  parameter int TWO_PI     = 6434,
  parameter int PI         = 3217,
  parameter int HALF_PI    = 1608,
  parameter int RED_STEPS  = 11,
  parameter int START_HOLD = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] angle_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cos_out,
  output logic         core_start_out,
  output logic [W-1:0] core_angle_out,
  input  logic         core_ready_in,
  input  logic [W-1:0] core_cos_in
);

  localparam int c_kw = $clog2(RED_STEPS);
  localparam int c_hw = $clog2(START_HOLD + 1);

  localparam logic [W-1:0]    c_two_pi    = W'(TWO_PI);
  localparam logic [W-1:0]    c_pi        = W'(PI);
  localparam logic [W-1:0]    c_half_pi   = W'(HALF_PI);
  localparam logic [W-1:0]    c_min       = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]    c_max       = {1'b0, {(W-1){1'b1}}};
  localparam logic [c_kw-1:0] c_k_top     = c_kw'(RED_STEPS - 1);
  localparam logic [c_hw-1:0] c_hold_last = c_hw'(START_HOLD - 1);

  if (FXP_SHIFT >= W - 1 || (TWO_PI << (RED_STEPS - 1)) >= (1 << (W - 1))) begin : g_bad_params
    $error("cos_range_reduce_ctrl: reduction ladder does not fit in W bits");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS    = 3'd1,
    S_REDUCE = 3'd2,
    S_FOLD1  = 3'd3,
    S_FOLD2  = 3'd4,
    S_START  = 3'd5,
    S_WAIT   = 3'd6,
    S_OUT    = 3'd7
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_angle;
  logic [W-1:0]    r_a;
  logic [c_kw-1:0] r_k;
  logic [c_hw-1:0] r_hold;
  logic            r_seen_low;
  logic            r_neg;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_cos;
  logic            r_core_start;
  logic [W-1:0]    r_core_angle;

  logic [W-1:0]    w_abs;
  logic [W-1:0]    w_step;

  // The most negative angle has no positive twin, so it saturates.
  always_comb begin
    w_abs = r_angle;
    if (r_angle[W-1]) begin
      w_abs = (r_angle == c_min) ? c_max : -r_angle;
    end
  end

  assign w_step = c_two_pi << r_k;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_angle      <= '0;
      r_a          <= '0;
      r_k          <= '0;
      r_hold       <= '0;
      r_seen_low   <= 1'b0;
      r_neg        <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_cos        <= '0;
      r_core_start <= 1'b0;
      r_core_angle <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_angle    <= angle_in;
            r_in_ready <= 1'b0;
            r_state    <= S_ABS;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_ABS: begin
          r_a     <= w_abs;
          r_k     <= c_k_top;
          r_state <= S_REDUCE;
        end
        S_REDUCE: begin
          if (r_a >= w_step) begin
            r_a <= r_a - w_step;
          end
          if (r_k == '0) begin
            r_state <= S_FOLD1;
          end else begin
            r_k <= r_k - c_kw'(1);
          end
        end
        S_FOLD1: begin
          if (r_a > c_pi) begin
            r_a <= c_two_pi - r_a;
          end
          r_state <= S_FOLD2;
        end
        S_FOLD2: begin
          if (r_a > c_half_pi) begin
            r_core_angle <= c_pi - r_a;
            r_neg        <= 1'b1;
          end else begin
            r_core_angle <= r_a;
            r_neg        <= 1'b0;
          end
          r_core_start <= 1'b1;
          r_hold       <= '0;
          r_seen_low   <= 1'b0;
          r_state      <= S_START;
        end
        // A stale ready=1 from a finished core must be seen to drop before waiting.
        S_START: begin
          if (r_hold >= c_hold_last && (r_seen_low || !core_ready_in)) begin
            r_core_start <= 1'b0;
            r_state      <= S_WAIT;
          end else begin
            if (r_hold < c_hold_last) begin
              r_hold <= r_hold + c_hw'(1);
            end
            if (!core_ready_in) begin
              r_seen_low <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (core_ready_in) begin
            r_cos       <= r_neg ? -core_cos_in : core_cos_in;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign cos_out        = r_cos;
  assign core_start_out = r_core_start;
  assign core_angle_out = r_core_angle;

endmodule
`default_nettype wire

// File: tb/tb_cos_range_reduce_ctrl.sv
`default_nettype none
// Bench for cos_range_reduce_ctrl: behavioural core stub plus a scoreboard of
// expected core angle and signed cosine per accepted angle.
module tb_cos_range_reduce_ctrl;

  localparam int W        = 24;
  localparam int CORE_LAT = 6;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] angle_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] cos_out;
  logic         core_start_out;
  logic [W-1:0] core_angle_out;
  logic         core_ready_in;
  logic [W-1:0] core_cos_in;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] cang;
    logic [W-1:0] cos;
  } exp_t;
  exp_t sb[$];

  cos_range_reduce_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .angle_in       (angle_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .cos_out        (cos_out),
    .core_start_out (core_start_out),
    .core_angle_out (core_angle_out),
    .core_ready_in  (core_ready_in),
    .core_cos_in    (core_cos_in)
  );

  always #5 clock = ~clock;

  // Stand-in core result: 1 - a^2/2 in Q.10.
  function automatic logic [W-1:0] cos_stub(input logic [W-1:0] a);
    longint v;
    v = longint'(a);
    return W'(1024 - ((v * v) >>> 11));
  endfunction

  // Core stub: ready after reset, busy CORE_LAT+1 cycles per start, then holds
  // its result with ready=1 until the next start.
  logic [W-1:0] c_ang;
  int           c_cnt;
  logic         c_busy;
  always_ff @(posedge clock) begin
    if (reset) begin
      core_ready_in <= 1'b0;
      core_cos_in   <= '0;
      c_busy        <= 1'b0;
      c_cnt         <= 0;
      c_ang         <= '0;
    end else if (c_busy) begin
      if (c_cnt == 0) begin
        c_busy        <= 1'b0;
        core_ready_in <= 1'b1;
        core_cos_in   <= cos_stub(c_ang);
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end else if (core_start_out) begin
      c_busy        <= 1'b1;
      core_ready_in <= 1'b0;
      c_cnt         <= CORE_LAT;
      c_ang         <= core_angle_out;
    end else begin
      core_ready_in <= 1'b1;
    end
  end

  // Reference reduction by plain modulo arithmetic.
  function automatic exp_t model(input logic [W-1:0] ang);
    exp_t   e;
    longint a;
    bit     neg;
    a = longint'(signed'(ang));
    if (a < 0) a = -a;
    if (a > 8388607) a = 8388607;
    a = a % 6434;
    if (a > 3217) a = 6434 - a;
    neg = 0;
    if (a > 1608) begin
      a   = 3217 - a;
      neg = 1;
    end
    e.cang = W'(a);
    e.cos  = neg ? -cos_stub(W'(a)) : cos_stub(W'(a));
    return e;
  endfunction

  // Drives one angle through; lat<0 marks a timeout.
  task automatic run_op(input logic [W-1:0] ang, input int hold, output int lat,
                        output logic [W-1:0] cang, output logic [W-1:0] cres,
                        output bit unstable);
    int n;
    logic [W-1:0] held;
    lat = -1; cang = '0; cres = '0; unstable = 0; n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1;
    angle_in = ang;
    @(negedge clock);
    in_valid = 1'b0;
    angle_in = W'($urandom);
    lat = 1;
    while (core_start_out !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
    cang = core_angle_out;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    if (out_valid !== 1'b1) begin lat = -2; return; end
    held = cos_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (cos_out !== held || out_valid !== 1'b1) unstable = 1;
    end
    cres = cos_out;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || cos_out !== '0 ||
        core_start_out !== 1'b0 || core_angle_out !== '0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b cos_out=%0h start=%b core_angle=%0h, required all 0",
               in_ready, out_valid, cos_out, core_start_out, core_angle_out);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_after_reset: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_known_angles();
    int angs [9]  = '{0, 3217, -18802, 2500, -8388608, 1608, 1609, 6434, -1};
    int cangs [9] = '{0, 0, 500, 717, 1329, 1608, 1608, 0, 1};
    bit negs [9]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    int lat;
    logic [W-1:0] cang, cres;
    bit unst;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      e.cang = W'(cangs[i]);
      e.cos  = negs[i] ? -cos_stub(W'(cangs[i])) : cos_stub(W'(cangs[i]));
      sb.push_back(e);
      run_op(W'(angs[i]), 0, lat, cang, cres, unst);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 15) begin
        n_fail++;
        $display("FAIL known[%0d] start_latency: got %0d, required 15", i, lat);
      end
      n_cmp++;
      if (cang !== e.cang) begin
        n_fail++;
        $display("FAIL known[%0d] core_angle: got %0d, required %0d", i, cang, e.cang);
      end
      n_cmp++;
      if (cres !== e.cos) begin
        n_fail++;
        $display("FAIL known[%0d] cos_out: got %0h, required %0h", i, cres, e.cos);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] ang, cang, cres;
    bit unst;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      ang = W'($urandom);
      sb.push_back(model(ang));
      run_op(ang, 0, lat, cang, cres, unst);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 15 || cang !== e.cang) begin
        n_fail++;
        $display("FAIL random[%0d] angle %0h: latency %0d core_angle %0d, required 15 and %0d",
                 i, ang, lat, cang, e.cang);
      end
      n_cmp++;
      if (cres !== e.cos) begin
        n_fail++;
        $display("FAIL random[%0d] cos_out: got %0h, required %0h", i, cres, e.cos);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] cang, cres;
    bit unst;
    exp_t e;
    int angs [3] = '{700, -2000, 3000};
    for (int i = 0; i < 3; i++) sb.push_back(model(W'(angs[i])));
    for (int i = 0; i < 3; i++) begin
      run_op(W'(angs[i]), 0, lat, cang, cres, unst);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 15 || cres !== e.cos) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: latency %0d cos_out %0h, required 15 and %0h",
                 i, lat, cres, e.cos);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] cang, cres;
    bit unst;
    exp_t e;
    sb.push_back(model(W'(-5000)));
    run_op(W'(-5000), 5, lat, cang, cres, unst);
    e = sb.pop_front();
    n_cmp++;
    if (unst !== 1'b0 || lat < 0) begin
      n_fail++;
      $display("FAIL backpressure_stable: unstable=%b latency=%0d, required 0 and >=0", unst, lat);
    end
    n_cmp++;
    if (cres !== e.cos) begin
      n_fail++;
      $display("FAIL backpressure cos_out: got %0h, required %0h", cres, e.cos);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    int lat;
    logic [W-1:0] cang, cres;
    bit unst;
    bit seen;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    in_valid = 1'b1;
    angle_in = W'(2500);
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (core_start_out !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    while (core_start_out !== 1'b0 && n < 80) begin @(negedge clock); n++; end
    n_cmp++;
    if (n >= 80 || core_angle_out !== W'(717)) begin
      n_fail++;
      $display("FAIL reach_wait: cycles %0d core_angle %0d, required <80 and 717", n, core_angle_out);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || cos_out !== '0 ||
        core_start_out !== 1'b0 || core_angle_out !== '0) begin
      n_fail++;
      $display("FAIL reset_in_wait: in_ready=%b out_valid=%b cos_out=%0h start=%b core_angle=%0h, required all 0",
               in_ready, out_valid, cos_out, core_start_out, core_angle_out);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL result_discarded: out_valid rose after reset, required it to stay 0");
    end
    sb.push_back(model(W'(-18802)));
    run_op(W'(-18802), 0, lat, cang, cres, unst);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 15 || cang !== e.cang || cres !== e.cos) begin
      n_fail++;
      $display("FAIL recovery: latency %0d core_angle %0d cos_out %0h, required 15 %0d %0h",
               lat, cang, cres, e.cang, e.cos);
    end
  endtask

  initial begin
    test_reset();
    test_known_angles();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
